wta_decoder: RTL and testbench
==============================

# wta_decoder

Receive-side companion of the winner-take-all nibble stage. It accepts the 8-bit WTA result byte, where the winning nibble stays in place and the losing nibble is zeroed. For each byte it decodes which channel won and by how much. Over fixed windows it tallies wins, errors and peak winner magnitude, and issues a report through a valid/ready handshake. It sits downstream of the WTA output register and feeds status and readout logic.

## Interface
- WINDOW, default 16: accepted samples per tally window; legal range 2..255.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- u_in  input  8  WTA result byte: [7:4] upper channel (id 1), [3:0] lower channel (id 0).
- in_valid  input  1  u_in holds a sample.
- in_ready  output  1  decoder can accept a sample; accept = in_valid && in_ready.
- dec_valid  output  1  one-cycle pulse: dec_* hold the most recently accepted sample.
- dec_id  output  1  winning channel: 1 = upper, 0 = lower.
- dec_val  output  4  winning magnitude.
- dec_err  output  1  accepted byte was illegal (both nibbles nonzero).
- rep_valid  output  1  report held on rep_* outputs.
- rep_ready  input  1  consumer takes report; take = rep_valid && rep_ready.
- rep_hi_cnt, rep_lo_cnt, rep_err_cnt  output  CW each  counts for the window; CW = $clog2(WINDOW+1).
- rep_major  output  1  1 if rep_hi_cnt >= rep_lo_cnt.
- rep_peak  output  4  largest dec_val among legal samples in the window.

## Operation
- Decode rules for u_in = {H,L}:
  - H!=0, L==0: id 1, val H.
  - H==0, L!=0: id 0, val L.
  - H==0, L==0: id 1, val 0. The upstream comparator uses >=, so an all-zero byte means the upper channel won.
  - H!=0, L!=0: err=1, id 0, val 0.
- Window state:
  - Counters: cnt (samples in window), hi, lo, err, and peak.
  - Every accepted sample increments cnt and exactly one of hi, lo or err.
  - peak updates only on legal samples. Invariant: hi + lo + err = cnt.
- Window close: when the accepted sample makes cnt == WINDOW:
  - Final counts, including that sample, load into rep_*.
  - rep_valid sets.
  - All window counters clear to 0 on the same edge.
- Report registers hold until taken, then rep_valid clears. The contents of rep_* after a take are don't-care.
- Backpressure: in_ready = !(rep_valid && cnt == WINDOW-1).
  - A new window accumulates freely while a report is pending.
  - Intake stalls only on the sample that would close the window.
  - in_ready never depends combinationally on rep_ready or in_valid.
- Ties: equal hi and lo give rep_major = 1.
- Illegal bytes still count toward the window; they are never dropped.
- Reset: all outputs and counters are 0, except in_ready = 1. Reset acts without a clock edge.
- Reset mid-window or with a report pending discards all state. Nothing is reported.

## Timing
- Decode latency is 1 cycle: dec_valid, dec_id, dec_val and dec_err register on the accepting edge. dec_valid is high for exactly one cycle per accepted sample.
- Between accepts, dec_id, dec_val and dec_err hold their last values.
- rep_valid rises on the edge that accepts the WINDOW-th sample. The report is visible in the same cycle as that sample's dec_valid.
- The report clears on the edge where rep_valid && rep_ready.
  - With rep_ready tied high, rep_valid lasts exactly 1 cycle.
  - A stalled closing sample is accepted at the earliest in the cycle after the take edge, since in_ready is then 1.
- A take and a window close never share an edge, because the closing sample is stalled while rep_valid is high.
- Back-to-back accepts are sustained at 1 sample/cycle whenever reports are taken promptly.

## Test plan
1. Reset check: assert rst_n=0 with no clock running → all outputs 0 and in_ready=1 immediately; release reset, then one in_valid with 0x90 → dec_valid pulses 1 cycle later.
2. Decode: feed 0x90, 0x07, 0x00, 0x35 → (id1, val9, err0), (id0, val7, err0), (id1, val0, err0), (err1, id0, val0).
3. WINDOW=4, rep_ready=1: feed 0x90, 0x07, 0x30, 0x35 → single-cycle report with hi=2, lo=1, err=1, major=1, peak=9; a fifth sample starts a fresh window with cnt=1.
4. WINDOW=4, tie: feed 0x05, 0x50, 0x02, 0x20 → hi=2, lo=2, err=0, major=1, peak=5.
5. WINDOW=4, backpressure: rep_ready=0 with continuous valid samples → first report held; 3 more samples accepted, then in_ready=0 on the 4th. Pulse rep_ready → the stalled sample is accepted the next cycle and the second report appears.
6. Async reset after 2 of 4 samples with a report pending → rep_valid=0 and counters cleared at once; a following 4-sample window reports only its own counts.

Source files
------------

// File: rtl/wta_decoder_if.sv
// Bus bundle for the WTA decoder: sample intake, per-sample decode
// result and the windowed report handshake. The decoder is the slave,
// the producer/consumer side is the master.
interface wta_decoder_if #(
  parameter int WINDOW = 16
);
  localparam int CW = $clog2(WINDOW + 1);

  // Sample intake
  logic [7:0]    u_in;
  logic          in_valid;
  logic          in_ready;

  // Per-sample decode result
  logic          dec_valid;
  logic          dec_id;
  logic [3:0]    dec_val;
  logic          dec_err;

  // Window report
  logic          rep_valid;
  logic          rep_ready;
  logic [CW-1:0] rep_hi_cnt;
  logic [CW-1:0] rep_lo_cnt;
  logic [CW-1:0] rep_err_cnt;
  logic          rep_major;
  logic [3:0]    rep_peak;

  modport slave (
    input  u_in, in_valid, rep_ready,
    output in_ready, dec_valid, dec_id, dec_val, dec_err,
    output rep_valid, rep_hi_cnt, rep_lo_cnt, rep_err_cnt, rep_major, rep_peak
  );

  modport master (
    output u_in, in_valid, rep_ready,
    input  in_ready, dec_valid, dec_id, dec_val, dec_err,
    input  rep_valid, rep_hi_cnt, rep_lo_cnt, rep_err_cnt, rep_major, rep_peak
  );
endinterface

// File: rtl/wta_decoder.sv
// Receive-side decoder for winner-take-all nibble bytes. Decodes the
// winning channel and magnitude of each accepted byte, tallies wins,
// errors and peak magnitude over fixed windows, and hands each window's
// totals to a consumer through a valid/ready report.
module wta_decoder #(
  parameter int WINDOW = 16
) (
  input logic         clk,
  input logic         rst_n,
  wta_decoder_if.slave bus
);
  localparam int            CW   = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [3:0]    hi_nib, lo_nib;
  logic          dec_id_d, dec_err_d;
  logic [3:0]    dec_val_d;
  logic          accept, in_ready;

  logic          dec_valid_q, dec_id_q, dec_err_q;
  logic [3:0]    dec_val_q;

  logic [CW-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d, werr_q, werr_d;
  logic [3:0]    peak_q, peak_d;

  logic          rep_valid_q, rep_valid_d, rep_major_q, rep_major_d;
  logic [CW-1:0] rep_hi_q, rep_hi_d, rep_lo_q, rep_lo_d, rep_err_q, rep_err_d;
  logic [3:0]    rep_peak_q, rep_peak_d;

  assign hi_nib = bus.u_in[7:4];
  assign lo_nib = bus.u_in[3:0];

  // Only the window-closing sample stalls, and only while the previous
  // report is still pending; purely a function of registered state.
  assign in_ready = !(rep_valid_q && (cnt_q == LAST));
  assign accept   = bus.in_valid && in_ready;

  // Decode the incoming byte; an all-zero byte is an upper-channel win
  // because the upstream comparator favours the upper nibble on ties.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dec_id_d  = 1'b1;
    dec_val_d = 4'd0;
    dec_err_d = 1'b0;
    if (hi_nib != 4'd0 && lo_nib != 4'd0) begin
      dec_err_d = 1'b1;
      dec_id_d  = 1'b0;
    end else if (hi_nib != 4'd0) begin
      dec_val_d = hi_nib;
    end else if (lo_nib != 4'd0) begin
      dec_id_d  = 1'b0;
      dec_val_d = lo_nib;
    end
  end

  // Window tally and report next-state: take clears the report, the
  // closing sample snapshots the totals and restarts the window.
  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    werr_d      = werr_q;
    peak_d      = peak_q;
    rep_valid_d = rep_valid_q;
    rep_hi_d    = rep_hi_q;
    rep_lo_d    = rep_lo_q;
    rep_err_d   = rep_err_q;
    rep_major_d = rep_major_q;
    rep_peak_d  = rep_peak_q;

    if (rep_valid_q && bus.rep_ready) begin
      rep_valid_d = 1'b0;
    end

    if (accept) begin
      cnt_d = cnt_q + ONE;
      if (dec_err_d) begin
        werr_d = werr_q + ONE;
      end else begin
        if (dec_id_d) hi_d = hi_q + ONE;
        else          lo_d = lo_q + ONE;
        if (dec_val_d > peak_q) peak_d = dec_val_d;
      end

      if (cnt_q == LAST) begin
        rep_valid_d = 1'b1;
        rep_hi_d    = hi_d;
        rep_lo_d    = lo_d;
        rep_err_d   = werr_d;
        rep_major_d = (hi_d >= lo_d);
        rep_peak_d  = peak_d;
        cnt_d       = '0;
        hi_d        = '0;
        lo_d        = '0;
        werr_d      = '0;
        peak_d      = 4'd0;
      end
    end
  end

  // State registers; reset discards any partial window and pending report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      dec_id_q    <= 1'b0;
      dec_val_q   <= 4'd0;
      dec_err_q   <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      werr_q      <= '0;
      peak_q      <= 4'd0;
      rep_valid_q <= 1'b0;
      rep_hi_q    <= '0;
      rep_lo_q    <= '0;
      rep_err_q   <= '0;
      rep_major_q <= 1'b0;
      rep_peak_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      dec_valid_q <= accept;
      if (accept) begin
        dec_id_q  <= dec_id_d;
        dec_val_q <= dec_val_d;
        dec_err_q <= dec_err_d;
      end
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      werr_q      <= werr_d;
      peak_q      <= peak_d;
      rep_valid_q <= rep_valid_d;
      rep_hi_q    <= rep_hi_d;
      rep_lo_q    <= rep_lo_d;
      rep_err_q   <= rep_err_d;
      rep_major_q <= rep_major_d;
      rep_peak_q  <= rep_peak_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec_id      = dec_id_q;
  assign bus.dec_val     = dec_val_q;
  assign bus.dec_err     = dec_err_q;
  assign bus.rep_valid   = rep_valid_q;
  assign bus.rep_hi_cnt  = rep_hi_q;
  assign bus.rep_lo_cnt  = rep_lo_q;
  assign bus.rep_err_cnt = rep_err_q;
  assign bus.rep_major   = rep_major_q;
  assign bus.rep_peak    = rep_peak_q;
endmodule

// File: tb/tb_wta_decoder.sv
// Directed bench for wta_decoder with WINDOW=4: decode rules, window
// reports, ties, backpressure and asynchronous reset.
module tb_wta_decoder;
  localparam int WINDOW = 4;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   checks;
  int   errors;

  wta_decoder_if #(.WINDOW(WINDOW)) bus ();

  wta_decoder #(.WINDOW(WINDOW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one rising edge; outputs are observed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.u_in      = 8'h00;
    bus.rep_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // {valid, id, val, err}
  function automatic logic [6:0] dec_vec();
    return {bus.dec_valid, bus.dec_id, bus.dec_val, bus.dec_err};
  endfunction

  // {valid, hi, lo, err, major, peak}
  function automatic logic [14:0] rep_vec();
    return {bus.rep_valid, bus.rep_hi_cnt, bus.rep_lo_cnt, bus.rep_err_cnt,
            bus.rep_major, bus.rep_peak};
  endfunction

  task automatic test_reset();
    logic [6:0]  d;
    logic [14:0] r;
    clk_en = 1'b0;
    bus.in_valid  = 1'b0;
    bus.u_in      = 8'h00;
    bus.rep_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    d = dec_vec();
    r = rep_vec();
    checks++;
    if (d !== 7'd0) begin errors++; $display("FAIL reset_dec: got %h want 00", d); end
    checks++;
    if (r !== 15'd0) begin errors++; $display("FAIL reset_rep: got %h want 0000", r); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    rst_n  = 1'b1;
    clk_en = 1'b1;
    bus.u_in     = 8'h90;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    d = dec_vec();
    checks++;
    if (d !== {1'b1, 1'b1, 4'd9, 1'b0}) begin errors++; $display("FAIL reset_first_dec: got %h want %h", d, {1'b1, 1'b1, 4'd9, 1'b0}); end
    step();
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_pulse: got %b want 0", bus.dec_valid); end
  endtask

  task automatic test_decode();
    logic [7:0] vin  [4] = '{8'h90, 8'h07, 8'h00, 8'h35};
    logic [6:0] vexp [4] = '{{1'b1, 1'b1, 4'd9, 1'b0}, {1'b1, 1'b0, 4'd7, 1'b0},
                             {1'b1, 1'b1, 4'd0, 1'b0}, {1'b1, 1'b0, 4'd0, 1'b1}};
    logic [6:0] d;
    do_reset();
    bus.rep_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.u_in = vin[i];
      step();
      d = dec_vec();
      checks++;
      if (d !== vexp[i]) begin errors++; $display("FAIL decode_%h: got %h want %h", vin[i], d, vexp[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.dec_id !== 1'b0 || bus.dec_err !== 1'b1) begin errors++; $display("FAIL decode_hold: got id %b err %b want id 0 err 1", bus.dec_id, bus.dec_err); end
  endtask

  task automatic test_window();
    logic [7:0]  vin [8] = '{8'h90, 8'h07, 8'h30, 8'h35, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [14:0] r;
    do_reset();
    bus.rep_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.u_in = vin[i];
      step();
      r = rep_vec();
      if (i == 2 || i == 4 || i == 6) begin
        checks++;
        if (bus.rep_valid !== 1'b0) begin errors++; $display("FAIL window_no_rep_%0d: got %b want 0", i, bus.rep_valid); end
      end
      if (i == 3) begin
        checks++;
        if (r !== {1'b1, 3'd2, 3'd1, 3'd1, 1'b1, 4'd9}) begin errors++; $display("FAIL window_rep1: got %h want %h", r, {1'b1, 3'd2, 3'd1, 3'd1, 1'b1, 4'd9}); end
      end
      if (i == 7) begin
        checks++;
        if (r !== {1'b1, 3'd0, 3'd4, 3'd0, 1'b0, 4'd4}) begin errors++; $display("FAIL window_rep2: got %h want %h", r, {1'b1, 3'd0, 3'd4, 3'd0, 1'b0, 4'd4}); end
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.rep_valid !== 1'b0) begin errors++; $display("FAIL window_rep_one_cycle: got %b want 0", bus.rep_valid); end
  endtask

  task automatic test_tie();
    logic [7:0]  vin [4] = '{8'h05, 8'h50, 8'h02, 8'h20};
    logic [14:0] r;
    do_reset();
    bus.rep_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.u_in = vin[i];
      step();
    end
    bus.in_valid = 1'b0;
    r = rep_vec();
    checks++;
    if (r !== {1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 4'd5}) begin errors++; $display("FAIL tie_rep: got %h want %h", r, {1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 4'd5}); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  vin [8] = '{8'h10, 8'h20, 8'h03, 8'h00, 8'h0A, 8'h0B, 8'h11, 8'hF0};
    logic [14:0] rep1 = {1'b1, 3'd3, 3'd1, 3'd0, 1'b1, 4'd3};
    logic [14:0] rep2 = {1'b1, 3'd1, 3'd2, 3'd1, 1'b0, 4'd15};
    logic [14:0] r;
    logic [6:0]  d;
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.u_in = vin[i];
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b want 1", i, bus.in_ready); end
      step();
    end
    r = rep_vec();
    checks++;
    if (r !== rep1) begin errors++; $display("FAIL bp_rep1_held: got %h want %h", r, rep1); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", bus.in_ready); end
    bus.u_in = vin[7];
    step();
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.rep_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled: got dec_valid %b rep_valid %b want 0 1", bus.dec_valid, bus.rep_valid); end
    bus.rep_ready = 1'b1;
    step();
    bus.rep_ready = 1'b0;
    checks++;
    if (bus.rep_valid !== 1'b0 || bus.dec_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_take: got rep_valid %b dec_valid %b in_ready %b want 0 0 1", bus.rep_valid, bus.dec_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    d = dec_vec();
    r = rep_vec();
    checks++;
    if (d !== {1'b1, 1'b1, 4'd15, 1'b0}) begin errors++; $display("FAIL bp_late_dec: got %h want %h", d, {1'b1, 1'b1, 4'd15, 1'b0}); end
    checks++;
    if (r !== rep2) begin errors++; $display("FAIL bp_rep2: got %h want %h", r, rep2); end
  endtask

  task automatic test_async_reset();
    logic [7:0]  vin [4] = '{8'h01, 8'h02, 8'h03, 8'h80};
    logic [14:0] r;
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.u_in = 8'h40;
      step();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    r = rep_vec();
    checks++;
    if (r !== 15'd0 || bus.dec_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got rep %h dec_valid %b in_ready %b want 0000 0 1", r, bus.dec_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    bus.rep_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.u_in = vin[i];
      step();
      if (i == 1) begin
        checks++;
        if (bus.rep_valid !== 1'b0) begin errors++; $display("FAIL async_early_rep: got %b want 0", bus.rep_valid); end
      end
    end
    bus.in_valid = 1'b0;
    r = rep_vec();
    checks++;
    if (r !== {1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 4'd8}) begin errors++; $display("FAIL async_rep: got %h want %h", r, {1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 4'd8}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    bus.u_in      = 8'h00;
    bus.in_valid  = 1'b0;
    bus.rep_ready = 1'b0;
    test_reset();
    test_decode();
    test_window();
    test_tie();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
